// File: rtl/pc_gen_if.sv
// Fetch-PC generator bus: redirect/trap sources from execute and commit,
// and the PC valid/ready handshake towards instruction fetch.
// master: the PC generator. slave: the surrounding pipeline.
interface pc_gen_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int SEL_WIDTH  = 2
);
    logic [SEL_WIDTH-1:0]  pc_sel;
    logic [ADDR_WIDTH-1:0] bra_addr;
    logic [ADDR_WIDTH-1:0] jal_addr;
    logic [ADDR_WIDTH-1:0] jalr_addr;
    logic                  redirect_valid;
    logic                  trap_valid;
    logic [ADDR_WIDTH-1:0] trap_vec;
    logic                  is_compressed;
    logic                  stall;
    logic                  pc_valid;
    logic                  pc_ready;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  misalign;
    logic [ADDR_WIDTH-1:0] bad_addr;

    modport master (
        input  pc_sel, bra_addr, jal_addr, jalr_addr, redirect_valid,
        input  trap_valid, trap_vec, is_compressed, stall, pc_ready,
        output pc_valid, pc, misalign, bad_addr
    );

    modport slave (
        output pc_sel, bra_addr, jal_addr, jalr_addr, redirect_valid,
        output trap_valid, trap_vec, is_compressed, stall, pc_ready,
        input  pc_valid, pc, misalign, bad_addr
    );
endinterface

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: registered fetch-PC generator with prioritised redirect
// (trap > jalr > jal > branch > sequential) and misaligned-target diversion
// to the trap vector.
// Optional feature macro: C_EXT_EN (16-bit instructions; INC 2/4 and
// halfword alignment). Without it INC is 4 and word alignment is required.
module pc_gen_unit #(
    parameter int          ADDR_WIDTH   = 64,
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter int          SEL_WIDTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_gen_if.master      bus
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_VECTOR);

`ifdef C_EXT_EN
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(1);
`else
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(3);
`endif

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DIVERT = 2'd2
    } state_t;

    // Target is misaligned when any bit under the alignment mask is set.
    function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] addr);
        return (addr & ALIGN_MASK) != {ADDR_WIDTH{1'b0}};
    endfunction

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic                  pc_valid_r;
    logic                  misalign_r;
    logic [ADDR_WIDTH-1:0] bad_addr_r;

    logic                  redir_s;
    logic [ADDR_WIDTH-1:0] target_s;
    logic [ADDR_WIDTH-1:0] inc_s;
    logic                  transfer_s;

`ifdef C_EXT_EN
    assign inc_s = bus.is_compressed ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4);
`else
    // is_compressed has no function without 16-bit instruction support.
    logic cmp_unused_s;
    assign cmp_unused_s = bus.is_compressed;
    assign inc_s        = ADDR_WIDTH'(4);
`endif

    assign transfer_s = pc_valid_r & bus.pc_ready & ~bus.stall;

    // Decode the redirect source; pc_sel of 0 means no redirect.
    always_comb begin
        redir_s  = 1'b0;
        target_s = {ADDR_WIDTH{1'b0}};
        if (bus.redirect_valid) begin
            case (bus.pc_sel)
                SEL_WIDTH'(3): begin
                    redir_s  = 1'b1;
                    target_s = bus.jalr_addr & ~ADDR_WIDTH'(1);
                end
                SEL_WIDTH'(2): begin
                    redir_s  = 1'b1;
                    target_s = bus.jal_addr;
                end
                SEL_WIDTH'(1): begin
                    redir_s  = 1'b1;
                    target_s = bus.bra_addr;
                end
                default: begin
                    redir_s  = 1'b0;
                    target_s = {ADDR_WIDTH{1'b0}};
                end
            endcase
        end else begin
            redir_s  = 1'b0;
            target_s = {ADDR_WIDTH{1'b0}};
        end
    end

    // Control FSM owning the PC, handshake valid and fault reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_BOOT;
            pc_r       <= RESET_PC;
            pc_valid_r <= 1'b0;
            misalign_r <= 1'b0;
            bad_addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            misalign_r <= 1'b0;
            case (state_r)
                ST_BOOT: begin
                    pc_valid_r <= 1'b1;
                    state_r    <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.trap_valid) begin
                        pc_r       <= bus.trap_vec;
                        pc_valid_r <= 1'b1;
                    end else if (redir_s) begin
                        if (is_misaligned(target_s)) begin
                            // Hold PC, drop valid, report on the way out of DIVERT.
                            bad_addr_r <= target_s;
                            pc_valid_r <= 1'b0;
                            state_r    <= ST_DIVERT;
                        end else begin
                            pc_r       <= target_s;
                            pc_valid_r <= 1'b1;
                        end
                    end else if (transfer_s) begin
                        pc_r <= pc_r + inc_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                ST_DIVERT: begin
                    // A concurrent trap loads the same vector, so it is absorbed.
                    misalign_r <= 1'b1;
                    pc_r       <= bus.trap_vec;
                    pc_valid_r <= 1'b1;
                    state_r    <= ST_RUN;
                end
                default: begin
                    pc_valid_r <= 1'b0;
                    state_r    <= ST_BOOT;
                end
            endcase
        end
    end

    assign bus.pc       = pc_r;
    assign bus.pc_valid = pc_valid_r;
    assign bus.misalign = misalign_r;
    assign bus.bad_addr = bad_addr_r;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed table-driven bench for pc_gen_unit (ADDR_WIDTH 32, reset 0x1000).
module tb_pc_gen_unit;

    localparam int AW = 32;
`ifdef C_EXT_EN
    localparam bit CEXT = 1'b1;
`else
    localparam bit CEXT = 1'b0;
`endif

    typedef struct {
        logic          trap;
        logic          rv;
        logic [1:0]    sel;
        logic [AW-1:0] tgt;
        logic [AW-1:0] tvec;
        logic          stall;
        logic          rdy;
        logic          cmp;
        logic          exp_pv;
        logic [AW-1:0] exp_pc;
        logic          exp_mis;
        logic [AW-1:0] exp_bad;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    vec_t tbl [23];

    pc_gen_if #(.ADDR_WIDTH(AW), .SEL_WIDTH(2)) bus ();

    pc_gen_unit #(
        .ADDR_WIDTH  (AW),
        .RESET_VECTOR(64'h1000),
        .SEL_WIDTH   (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic trap, logic rv, logic [1:0] sel,
                                logic [AW-1:0] tgt, logic [AW-1:0] tvec,
                                logic stall, logic rdy, logic cmp,
                                logic epv, logic [AW-1:0] epc,
                                logic emis, logic [AW-1:0] ebad);
        vec_t v;
        v.trap = trap; v.rv = rv; v.sel = sel; v.tgt = tgt; v.tvec = tvec;
        v.stall = stall; v.rdy = rdy; v.cmp = cmp;
        v.exp_pv = epv; v.exp_pc = epc; v.exp_mis = emis; v.exp_bad = ebad;
        return v;
    endfunction

    task automatic chk(input string name, input logic [AW-1:0] act,
                       input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Unselected target inputs carry aligned decoys so a wrong mux pick shows.
    task automatic drive(input vec_t v);
        bus.trap_valid     = v.trap;
        bus.redirect_valid = v.rv;
        bus.pc_sel         = v.sel;
        bus.bra_addr       = (v.sel == 2'd1) ? v.tgt : 32'h0000_B000;
        bus.jal_addr       = (v.sel == 2'd2) ? v.tgt : 32'h0000_A000;
        bus.jalr_addr      = (v.sel == 2'd3) ? v.tgt : 32'h0000_C000;
        bus.trap_vec       = v.tvec;
        bus.stall          = v.stall;
        bus.pc_ready       = v.rdy;
        bus.is_compressed  = v.cmp;
    endtask

    task automatic idle();
        drive(mk(1'b0, 1'b0, 2'd0, 32'h0, 32'h8800, 1'b0, 1'b0, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();

        //               trap  rv    sel   tgt           tvec          stall rdy   cmp   pv    pc                                 mis   bad
        tbl[0]  = mk(1'b0, 1'b0, 2'd0, 32'h0,        32'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000,                          1'b0, 32'h0);
        tbl[1]  = mk(1'b0, 1'b0, 2'd0, 32'h0,        32'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1004,                          1'b0, 32'h0);
        tbl[2]  = mk(1'b0, 1'b0, 2'd0, 32'h0,        32'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1008,                          1'b0, 32'h0);
        tbl[3]  = mk(1'b0, 1'b0, 2'd0, 32'h0,        32'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1008,                          1'b0, 32'h0);
        tbl[4]  = mk(1'b0, 1'b0, 2'd0, 32'h0,        32'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1008,                          1'b0, 32'h0);
        tbl[5]  = mk(1'b0, 1'b0, 2'd0, 32'h0,        32'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100C,                          1'b0, 32'h0);
        tbl[6]  = mk(1'b0, 1'b0, 2'd0, 32'h0,        32'h8000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100C,                          1'b0, 32'h0);
        tbl[7]  = mk(1'b0, 1'b0, 2'd0, 32'h0,        32'h8000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100C,                          1'b0, 32'h0);
        tbl[8]  = mk(1'b0, 1'b0, 2'd0, 32'h0,        32'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1010,                          1'b0, 32'h0);
        tbl[9]  = mk(1'b1, 1'b1, 2'd2, 32'h2000,     32'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000,                          1'b0, 32'h0);
        tbl[10] = mk(1'b0, 1'b1, 2'd2, 32'h2000,     32'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000,                          1'b0, 32'h0);
        tbl[11] = mk(1'b0, 1'b1, 2'd3, 32'h3001,     32'h8000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3000,                          1'b0, 32'h0);
        tbl[12] = mk(1'b0, 1'b1, 2'd0, 32'h7000,     32'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3004,                          1'b0, 32'h0);
        tbl[13] = mk(1'b0, 1'b0, 2'd2, 32'h5000,     32'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3004,                          1'b0, 32'h0);
        tbl[14] = mk(1'b0, 1'b1, 2'd1, 32'h4002,     32'h8000, 1'b0, 1'b1, 1'b0, CEXT, CEXT ? 32'h4002 : 32'h3004,        1'b0, CEXT ? 32'h0 : 32'h4002);
        tbl[15] = mk(1'b1, 1'b0, 2'd0, 32'h0,        32'h8800, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8800,                          !CEXT, CEXT ? 32'h0 : 32'h4002);
        tbl[16] = mk(1'b0, 1'b0, 2'd0, 32'h0,        32'h8800, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8804,                          1'b0, CEXT ? 32'h0 : 32'h4002);
        tbl[17] = mk(1'b0, 1'b1, 2'd2, 32'h10,       32'h8800, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10,                            1'b0, CEXT ? 32'h0 : 32'h4002);
        tbl[18] = mk(1'b0, 1'b0, 2'd0, 32'h0,        32'h8800, 1'b0, 1'b1, 1'b1, 1'b1, CEXT ? 32'h12 : 32'h14,            1'b0, CEXT ? 32'h0 : 32'h4002);
        tbl[19] = mk(1'b0, 1'b1, 2'd2, 32'hFFFF_FFFC, 32'h8800, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC,                    1'b0, CEXT ? 32'h0 : 32'h4002);
        tbl[20] = mk(1'b0, 1'b0, 2'd0, 32'h0,        32'h8800, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,                             1'b0, CEXT ? 32'h0 : 32'h4002);
        tbl[21] = mk(1'b0, 1'b1, 2'd3, 32'h5003,     32'h8800, 1'b0, 1'b1, 1'b0, CEXT, CEXT ? 32'h5002 : 32'h0,           1'b0, CEXT ? 32'h0 : 32'h5002);
        tbl[22] = mk(1'b0, 1'b0, 2'd0, 32'h0,        32'h8800, 1'b0, 1'b0, 1'b0, 1'b1, CEXT ? 32'h5002 : 32'h8800,        !CEXT, CEXT ? 32'h0 : 32'h5002);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",       bus.pc,                 32'h1000);
        chk("rst_pc_valid", AW'(bus.pc_valid),      32'h0);
        chk("rst_misalign", AW'(bus.misalign),      32'h0);
        chk("rst_bad_addr", bus.bad_addr,           32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_pc_valid", AW'(bus.pc_valid), 32'h0);

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc_valid", i), AW'(bus.pc_valid), AW'(tbl[i].exp_pv));
            chk($sformatf("v%0d_pc", i),       bus.pc,            tbl[i].exp_pc);
            chk($sformatf("v%0d_misalign", i), AW'(bus.misalign), AW'(tbl[i].exp_mis));
            chk($sformatf("v%0d_bad_addr", i), bus.bad_addr,      tbl[i].exp_bad);
            @(negedge clk);
        end

        // Enter DIVERT with an odd branch target, then reset mid-DIVERT.
        drive(mk(1'b0, 1'b1, 2'd1, 32'h6001, 32'h8800, 1'b0, 1'b1, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0));
        @(posedge clk);
        #1;
        chk("div_pc_valid", AW'(bus.pc_valid), 32'h0);
        chk("div_bad_addr", bus.bad_addr,      32'h6001);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc",       bus.pc,            32'h1000);
        chk("mid_rst_pc_valid", AW'(bus.pc_valid), 32'h0);
        chk("mid_rst_misalign", AW'(bus.misalign), 32'h0);
        chk("mid_rst_bad_addr", bus.bad_addr,      32'h0);
        @(posedge clk);
        #1;
        chk("held_rst_misalign", AW'(bus.misalign), 32'h0);
        chk("held_rst_pc",       bus.pc,            32'h1000);
        @(negedge clk);
        rst_n = 1'b1;
        bus.pc_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("reboot_pc_valid", AW'(bus.pc_valid), 32'h1);
        chk("reboot_pc",       bus.pc,            32'h1000);
        @(posedge clk);
        #1;
        chk("reboot_seq_pc",   bus.pc,            32'h1004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
